// File: rtl/rv_imm_pkg.sv
// Shared RV32 immediate-format constants, error codes and a range helper.
// The decode-stage extractor uses the same type-bit indices.
package rv_imm_pkg;

  localparam int unsigned IMM_J = 0;
  localparam int unsigned IMM_U = 1;
  localparam int unsigned IMM_B = 2;
  localparam int unsigned IMM_S = 3;
  localparam int unsigned IMM_I = 4;

  localparam logic [4:0] SEL_I = 5'b1 << IMM_I;
  localparam logic [4:0] SEL_S = 5'b1 << IMM_S;
  localparam logic [4:0] SEL_B = 5'b1 << IMM_B;
  localparam logic [4:0] SEL_U = 5'b1 << IMM_U;
  localparam logic [4:0] SEL_J = 5'b1 << IMM_J;

  typedef logic [1:0] imm_err_t;

  localparam imm_err_t IMM_OK    = 2'd0;
  localparam imm_err_t IMM_RANGE = 2'd1;
  localparam imm_err_t IMM_ALIGN = 2'd2;
  localparam imm_err_t IMM_TYPE  = 2'd3;

  // True when v equals the sign-extension of v[msb:0], i.e. bits msb..31 all agree.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic [31:0] upper;
    upper = 32'hFFFF_FFFF << msb;
    return ((v & upper) == upper) || ((v & upper) == 32'h0);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle of the immediate encoder.
interface imm_encoder_if import rv_imm_pkg::*; #(
  parameter int unsigned XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_template;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_type;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  imm_err_t        out_err;

  modport master (
    output in_valid, in_template, in_imm, in_type, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_template, in_imm, in_type, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/imm_pack.sv
// Combinational RV32 immediate scatter and range/alignment check.
module imm_pack import rv_imm_pkg::*; (
  input  logic [31:0] template,
  input  logic [31:0] imm,
  input  logic [4:0]  imm_type,
  output logic [31:0] instr,
  output imm_err_t    err
);

  always_comb begin
    instr = template;
    err   = IMM_OK;
    unique case (imm_type)
      SEL_I: begin
        instr[31:20] = imm[11:0];
        if (!fits_signed(imm, 11)) err = IMM_RANGE;
      end
      SEL_S: begin
        instr[31:25] = imm[11:5];
        instr[11:7]  = imm[4:0];
        if (!fits_signed(imm, 11)) err = IMM_RANGE;
      end
      SEL_B: begin
        instr[31]    = imm[12];
        instr[30:25] = imm[10:5];
        instr[11:8]  = imm[4:1];
        instr[7]     = imm[11];
        if (imm[0])                  err = IMM_ALIGN;
        else if (!fits_signed(imm, 12)) err = IMM_RANGE;
      end
      SEL_U: begin
        instr[31:12] = imm[31:12];
        if (imm[11:0] != 12'h0) err = IMM_RANGE;
      end
      SEL_J: begin
        instr[31]    = imm[20];
        instr[30:21] = imm[10:1];
        instr[20]    = imm[11];
        instr[19:12] = imm[19:12];
        if (imm[0])                  err = IMM_ALIGN;
        else if (!fits_signed(imm, 20)) err = IMM_RANGE;
      end
      default: err = IMM_TYPE;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: 1-cycle output register, one skid entry and
// saturating OK/error transfer counters.
module imm_encoder import rv_imm_pkg::*; #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  logic [XLEN-1:0]  pack_instr;
  imm_err_t         pack_err;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_instr_q, out_instr_d;
  imm_err_t         out_err_q, out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_instr_q, skid_instr_d;
  imm_err_t         skid_err_q, skid_err_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;

  logic accept, xfer, out_free;

  imm_pack u_pack (
    .template (bus.in_template),
    .imm      (bus.in_imm),
    .imm_type (bus.in_type),
    .instr    (pack_instr),
    .err      (pack_err)
  );

  // Ready depends only on the skid register, never on out_ready.
  assign bus.in_ready = !skid_valid_q && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign xfer         = out_valid_q && bus.out_ready;
  assign out_free     = !out_valid_q || xfer;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_err_d   = skid_err_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_instr_d = pack_instr;
          out_err_d   = pack_err;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = pack_instr;
      skid_err_d   = pack_err;
    end
  end

  always_comb begin
    cnt_ok_d  = cnt_ok_q;
    cnt_err_d = cnt_err_q;
    if (xfer) begin
      if (out_err_q == IMM_OK) begin
        if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + CNT_W'(1);
      end else begin
        if (cnt_err_q != '1) cnt_err_d = cnt_err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_err_q    <= IMM_OK;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_err_q   <= IMM_OK;
      cnt_ok_q     <= '0;
      cnt_err_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_err_q   <= skid_err_d;
      cnt_ok_q     <= cnt_ok_d;
      cnt_err_q    <= cnt_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_err   = out_err_q;
  assign cnt_ok        = cnt_ok_q;
  assign cnt_err       = cnt_err_q;

endmodule
